// File: rtl/prbs_tx_pkg.sv
// Shared definitions for the PRBS9 transmitter: FSM encoding, PRBS9 taps,
// default seed and the symbol amplitude helper.
package prbs_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    // x^9 + x^5 + 1: output and feedback taken from bit 8, feedback mixes bit 4
    localparam int unsigned PRBS9_LEN    = 9;
    localparam int unsigned PRBS9_TAP_HI = 8;
    localparam int unsigned PRBS9_TAP_LO = 4;

    localparam logic [8:0] PRBS9_SEED_DEFAULT = 9'h1AA;

    // Full-scale symbol magnitude for a given number of fractional bits
    function automatic logic [31:0] prbs_amp(input int unsigned nbf);
        return (32'd1 << nbf) - 32'd1;
    endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 Fibonacci LFSR: load reseeds, step shifts once, o_bit is the MSB.
module prbs9_lfsr
    import prbs_tx_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_SEED_DEFAULT
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_step,
    output logic o_bit
);

    logic [PRBS9_LEN-1:0] lfsr_r;

    // Shift register: reseed has priority over stepping
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_r <= SEED;
        end else if (i_load) begin
            lfsr_r <= SEED;
        end else if (i_step) begin
            lfsr_r <= {lfsr_r[PRBS9_LEN-2:0], lfsr_r[PRBS9_TAP_HI] ^ lfsr_r[PRBS9_TAP_LO]};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign o_bit = lfsr_r[PRBS9_TAP_HI];

endmodule

// File: rtl/prbs_tx.sv
// PRBS9 symbol transmitter with zero-stuffed oversampled output.
// Optional error injection is compiled in with PRBS_TX_ERR_INJ_EN.
module prbs_tx
    import prbs_tx_pkg::*;
#(
    parameter int         NB_OUTPUT  = 8,
    parameter int         NBF_OUTPUT = 7,
    parameter int         N_PHASES   = 4,
    parameter logic [8:0] SEED       = PRBS9_SEED_DEFAULT,
    parameter int         N_SYMBOLS  = 0,
    parameter int         NB_SYM_CNT = 64
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_inject,
    output logic [NB_OUTPUT-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic [NB_SYM_CNT-1:0] o_sym_cnt,
    output logic [15:0]           o_inj_cnt
);

    localparam int                    PH_W       = $clog2(N_PHASES);
    localparam logic [PH_W-1:0]       PH_LAST    = PH_W'(N_PHASES - 1);
    localparam logic [NB_OUTPUT-1:0]  AMP_POS    = NB_OUTPUT'(prbs_amp(NBF_OUTPUT));
    localparam logic [NB_OUTPUT-1:0]  AMP_NEG    = ~AMP_POS + {{(NB_OUTPUT-1){1'b0}}, 1'b1};
    localparam logic [NB_SYM_CNT-1:0] SYM_TARGET = NB_SYM_CNT'(N_SYMBOLS);

    state_e                  state_r;
    state_e                  state_s;
    logic [PH_W-1:0]         phase_r;
    logic [NB_SYM_CNT-1:0]   sym_cnt_r;
    logic [NB_OUTPUT-1:0]    data_r;
    logic                    valid_r;
    logic                    prbs_bit_s;
    logic                    burst_done_s;
    logic                    enter_run_s;
    logic                    emit_s;
    logic                    invert_s;
    logic                    sym_bit_s;

    prbs9_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_load  (enter_run_s),
        .i_step  (emit_s),
        .o_bit   (prbs_bit_s)
    );

    // Next-state logic; nothing moves while the block is disabled
    always_comb begin
        state_s      = state_r;
        burst_done_s = (N_SYMBOLS != 0) && (sym_cnt_r == SYM_TARGET);
        if (i_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) state_s = ST_RUN;
                    else         state_s = ST_IDLE;
                end
                ST_RUN: begin
                    // stop dominates; start while running is ignored
                    if (i_stop || burst_done_s) state_s = ST_STOP;
                    else                        state_s = ST_RUN;
                end
                ST_STOP: begin
                    if (i_start) state_s = ST_RUN;
                    else         state_s = ST_STOP;
                end
                default: state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Per-cycle qualifiers: run entry reseeds, phase 0 in RUN emits a symbol
    always_comb begin
        enter_run_s = i_en && (state_r != ST_RUN) && (state_s == ST_RUN);
        emit_s      = i_en && (state_r == ST_RUN) && (phase_r == '0);
        sym_bit_s   = prbs_bit_s ^ invert_s;
    end

    // FSM state register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Oversampling phase counter, restarted on every run entry
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_r <= '0;
        end else if (enter_run_s) begin
            phase_r <= '0;
        end else if (i_en && (state_r == ST_RUN)) begin
            if (phase_r == PH_LAST) phase_r <= '0;
            else                    phase_r <= phase_r + 1'b1;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Registered symbol output: bit 1 maps to the negative level
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (i_en) begin
            if (emit_s) begin
                data_r  <= sym_bit_s ? AMP_NEG : AMP_POS;
                valid_r <= 1'b1;
            end else begin
                data_r  <= '0;
                valid_r <= 1'b0;
            end
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    // Saturating emitted-symbol counter
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sym_cnt_r <= '0;
        end else if (enter_run_s) begin
            sym_cnt_r <= '0;
        end else if (emit_s && (sym_cnt_r != '1)) begin
            sym_cnt_r <= sym_cnt_r + 1'b1;
        end else begin
            sym_cnt_r <= sym_cnt_r;
        end
    end

`ifdef PRBS_TX_ERR_INJ_EN
    logic        inj_pend_r;
    logic [15:0] inj_cnt_r;

    assign invert_s = emit_s & inj_pend_r;

    // Injection request latch and saturating count; repeat requests merge
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inj_pend_r <= 1'b0;
            inj_cnt_r  <= 16'h0000;
        end else if (enter_run_s) begin
            inj_pend_r <= 1'b0;
            inj_cnt_r  <= 16'h0000;
        end else if (emit_s && inj_pend_r) begin
            inj_pend_r <= 1'b0;
            if (inj_cnt_r != 16'hFFFF) inj_cnt_r <= inj_cnt_r + 16'h0001;
            else                       inj_cnt_r <= inj_cnt_r;
        end else if (i_en && i_inject) begin
            inj_pend_r <= 1'b1;
            inj_cnt_r  <= inj_cnt_r;
        end else begin
            inj_pend_r <= inj_pend_r;
            inj_cnt_r  <= inj_cnt_r;
        end
    end

    assign o_inj_cnt = inj_cnt_r;
`else
    // Injection not built: the request input is masked off entirely
    assign invert_s  = emit_s & i_inject & 1'b0;
    assign o_inj_cnt = 16'h0000;
`endif

    assign o_data    = data_r;
    assign o_valid   = valid_r & i_en;
    assign o_busy    = (state_r == ST_RUN);
    assign o_sym_cnt = sym_cnt_r;

endmodule

// File: tb/tb_prbs_tx.sv
// Directed bench for prbs_tx: a continuous instance and a 10-symbol burst instance.
module tb_prbs_tx;

    logic clk;
    logic rst_n;
    logic en;
    logic start;
    logic stop;
    logic inject;
    logic start_b;
    logic stop_b;
    logic inject_b;

    logic [7:0]  a_data,    b_data;
    logic        a_valid,   b_valid;
    logic        a_busy,    b_busy;
    logic [63:0] a_sym_cnt, b_sym_cnt;
    logic [15:0] a_inj_cnt, b_inj_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cur_sym  = 0;
    int vcount_b = 0;
    logic sel = 1'b0;
    logic [8:0] m;
    logic [7:0] first9 [0:8] = '{8'h81, 8'h81, 8'h7F, 8'h81, 8'h7F, 8'h81, 8'h7F, 8'h81, 8'h7F};

`ifdef PRBS_TX_ERR_INJ_EN
    localparam logic INJ_ON = 1'b1;
`else
    localparam logic INJ_ON = 1'b0;
`endif

    prbs_tx u_dut (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_start   (start),
        .i_stop    (stop),
        .i_inject  (inject),
        .o_data    (a_data),
        .o_valid   (a_valid),
        .o_busy    (a_busy),
        .o_sym_cnt (a_sym_cnt),
        .o_inj_cnt (a_inj_cnt)
    );

    prbs_tx #(.N_SYMBOLS(10)) u_dut_burst (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_start   (start_b),
        .i_stop    (stop_b),
        .i_inject  (inject_b),
        .o_data    (b_data),
        .o_valid   (b_valid),
        .o_busy    (b_busy),
        .o_sym_cnt (b_sym_cnt),
        .o_inj_cnt (b_inj_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count burst-instance valid samples
    always @(posedge clk) if (b_valid === 1'b1) vcount_b++;

    wire [7:0]  obs_data  = sel ? b_data    : a_data;
    wire        obs_valid = sel ? b_valid   : a_valid;
    wire [63:0] obs_cnt   = sel ? b_sym_cnt : a_sym_cnt;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (sym %0d): got %0h expected %0h", tag, cur_sym, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] map_bit(input logic b);
        return b ? 8'h81 : 8'h7F;
    endfunction

    // reference PRBS9 from the polynomial x^9+x^5+1
    task automatic model_next(output logic [7:0] d);
        d = map_bit(m[8]);
        m = {m[7:0], m[8] ^ m[4]};
    endtask

    // Entered at the negedge where symbol s is visible; leaves at the next symbol.
    // act: 0 none, 1 freeze 7 cycles, 2 start pulse, 3 inject pulse, 4 stop+start, 5 glitch en
    task automatic run_sym(input int s, input logic [7:0] exp, input int act);
        cur_sym = s;
        check_value("valid", {63'd0, obs_valid}, 64'd1);
        check_value("data", {56'd0, obs_data}, {56'd0, exp});
        check_value("sym_cnt", obs_cnt, 64'(s));
        if (act == 5) begin
            en = 1'b0;
            #1;
            check_value("en_gate", {63'd0, obs_valid}, 64'd0);
            en = 1'b1;
        end
        tick();
        check_value("gap_valid", {63'd0, obs_valid}, 64'd0);
        check_value("gap_data", {56'd0, obs_data}, 64'd0);
        if (act == 1) begin
            en = 1'b0;
            repeat (7) begin
                tick();
                check_value("frz_valid", {63'd0, obs_valid}, 64'd0);
            end
            check_value("frz_cnt", obs_cnt, 64'(s));
            en = 1'b1;
        end
        if (act == 2) start = 1'b1;
        if (act == 3) inject = 1'b1;
        if (act == 4) begin
            start = 1'b1;
            stop  = 1'b1;
        end
        tick();
        start = 1'b0; stop = 1'b0; inject = 1'b0;
        check_value("gap_valid", {63'd0, obs_valid}, 64'd0);
        tick();
        check_value("gap_data", {56'd0, obs_data}, 64'd0);
        tick();
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; inject = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; inject_b = 1'b0;
        repeat (3) tick();
        check_value("rst_data", {56'd0, a_data}, 64'd0);
        check_value("rst_valid", {63'd0, a_valid}, 64'd0);
        check_value("rst_busy", {63'd0, a_busy}, 64'd0);
        check_value("rst_cnt", a_sym_cnt, 64'd0);
        check_value("rst_inj", {48'd0, a_inj_cnt}, 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check_value("idle_busy", {63'd0, a_busy}, 64'd0);
        check_value("idle_valid", {63'd0, a_valid}, 64'd0);

        // continuous run: period 511, freeze and en glitch mid-burst
        start = 1'b1; tick(); start = 1'b0;
        check_value("run_busy", {63'd0, a_busy}, 64'd1);
        check_value("run_lat", {63'd0, a_valid}, 64'd0);
        tick();
        m = 9'h1AA;
        for (int s = 1; s <= 520; s++) begin
            model_next(d);
            if (s <= 9 || s >= 512) d = first9[(s - 1) % 511];
            run_sym(s, d, (s == 30) ? 1 : ((s == 40) ? 5 : 0));
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check_value("stop_busy", {63'd0, a_busy}, 64'd0);
        check_value("stop_valid", {63'd0, a_valid}, 64'd0);
        check_value("stop_cnt", a_sym_cnt, 64'd521);
        repeat (3) tick();
        check_value("stop_data", {56'd0, a_data}, 64'd0);

        // restart from STOP, ignored start in RUN, injection at symbol 20
        start = 1'b1; tick(); start = 1'b0; tick();
        m = 9'h1AA;
        for (int s = 1; s <= 25; s++) begin
            model_next(d);
            if (s == 21 && INJ_ON) d = ~d + 8'd1;
            run_sym(s, d, (s == 3) ? 2 : ((s == 20) ? 3 : 0));
            if (s == 21) check_value("inj_cnt", {48'd0, a_inj_cnt}, {63'd0, INJ_ON});
        end

        // pending injection then asynchronous reset mid-burst
        inject = 1'b1; tick(); inject = 1'b0;
        repeat (3) tick();
        cur_sym = 27;
        check_value("pre_rst_valid", {63'd0, a_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_value("arst_valid", {63'd0, a_valid}, 64'd0);
        check_value("arst_data", {56'd0, a_data}, 64'd0);
        check_value("arst_busy", {63'd0, a_busy}, 64'd0);
        check_value("arst_cnt", a_sym_cnt, 64'd0);
        check_value("arst_inj", {48'd0, a_inj_cnt}, 64'd0);
        tick(); rst_n = 1'b1;
        repeat (2) tick();
        check_value("post_rst_busy", {63'd0, a_busy}, 64'd0);
        start = 1'b1; tick(); start = 1'b0; tick();
        run_sym(1, 8'h81, 4);
        check_value("post_rst_inj", {48'd0, a_inj_cnt}, 64'd0);
        check_value("stopwins_busy", {63'd0, a_busy}, 64'd0);
        check_value("stopwins_valid", {63'd0, a_valid}, 64'd0);

        // burst of 10 symbols on the second instance
        sel = 1'b1;
        vcount_b = 0;
        start_b = 1'b1; tick(); start_b = 1'b0; tick();
        m = 9'h1AA;
        for (int s = 1; s <= 9; s++) begin
            model_next(d);
            run_sym(s, d, 0);
        end
        model_next(d);
        cur_sym = 10;
        check_value("b10_valid", {63'd0, b_valid}, 64'd1);
        check_value("b10_data", {56'd0, b_data}, {56'd0, d});
        check_value("b10_cnt", b_sym_cnt, 64'd10);
        check_value("b10_busy", {63'd0, b_busy}, 64'd1);
        tick();
        check_value("b_stop_busy", {63'd0, b_busy}, 64'd0);
        repeat (12) tick();
        check_value("b_vcount", 64'(vcount_b), 64'd10);
        check_value("b_hold_cnt", b_sym_cnt, 64'd10);
        start_b = 1'b1; tick(); start_b = 1'b0; tick();
        run_sym(1, 8'h81, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
